// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the display scan controller and its neighbours:
// the controls it reads and the pin-level / mux-select signals it drives.
interface display_scan_ctrl_if;
   logic       display_on;
   logic [3:0] blink_en;
   logic [3:0] dp_mask;
   logic [1:0] sel;
   logic [3:0] anode_n;
   logic       dp_n;
   logic       digit_tick;
   logic       blink_phase;

   // Controller side: reads the controls, drives select, anodes and status.
   modport master (
      input  display_on, blink_en, dp_mask,
      output sel, anode_n, dp_n, digit_tick, blink_phase
   );

   // Consumer side: drives the controls, observes the scan outputs.
   modport slave (
      output display_on, blink_en, dp_mask,
      input  sel, anode_n, dp_n, digit_tick, blink_phase
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit common-anode 7-segment
// display: digit select, anti-ghosting dead time, per-digit blink and
// global display enable. All outputs are registered from next-state values
// so that sel, anode_n and dp_n always change on the same edge.
module display_scan_ctrl #(
   parameter int REFRESH_DIV  = 250000,
   parameter int DEAD_CYCLES  = 1000,
   parameter int BLINK_FRAMES = 100
) (
   input  logic                 clk,
   input  logic                 rst_n,
   display_scan_ctrl_if.master  bus
);

   // Dead time is always shorter than a slot, so it shares the prescaler width.
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0] prescaler, prescaler_next;
   logic [PW-1:0] dead_cnt, dead_next;
   logic [FW-1:0] frame_cnt, frame_next;
   logic [1:0]    sel_cnt, sel_next;
   logic          phase, phase_next;
   logic [3:0]    anodes, anodes_next;
   logic          dp, dp_next;
   logic          tick;
   logic          wrap;
   logic          frame_done;
   logic          blank;

   // Next-state and next-output computation for the scan, dead time and blink.
   always_comb begin
      wrap           = (prescaler == PW'(REFRESH_DIV - 1));
      prescaler_next = wrap ? '0 : prescaler + 1'b1;
      sel_next       = wrap ? sel_cnt + 2'd1 : sel_cnt;

      dead_next = dead_cnt;
      if (wrap)
         dead_next = PW'(DEAD_CYCLES);
      else if (dead_cnt != '0)
         dead_next = dead_cnt - 1'b1;

      // Blink phase only moves on the 3->0 boundary, so frames never blink partially.
      frame_done = wrap && (sel_cnt == 2'd3);
      frame_next = frame_cnt;
      phase_next = phase;
      if (frame_done) begin
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_next = '0;
            phase_next = ~phase;
         end else begin
            frame_next = frame_cnt + 1'b1;
         end
      end

      blank       = !bus.display_on || (dead_next != '0) ||
                    (phase_next && bus.blink_en[sel_next]);
      anodes_next = blank ? 4'b1111 : ~(4'b0001 << sel_next);
      dp_next     = blank ? 1'b1 : ~bus.dp_mask[sel_next];
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler <= '0;
         sel_cnt   <= 2'd0;
         dead_cnt  <= '0;
         frame_cnt <= '0;
         phase     <= 1'b0;
         anodes    <= 4'b1111;
         dp        <= 1'b1;
         tick      <= 1'b0;
      end else begin
         prescaler <= prescaler_next;
         sel_cnt   <= sel_next;
         dead_cnt  <= dead_next;
         frame_cnt <= frame_next;
         phase     <= phase_next;
         anodes    <= anodes_next;
         dp        <= dp_next;
         tick      <= wrap;
      end
   end

   assign bus.sel         = sel_cnt;
   assign bus.anode_n     = anodes;
   assign bus.dp_n        = dp;
   assign bus.digit_tick  = tick;
   assign bus.blink_phase = phase;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed vector table after reset, directed
// blink / display-off / mid-run reset sequences, then random inputs, all
// cross-checked against a timeline model built from the elapsed cycle count.
module tb_display_scan_ctrl;
   localparam int RD = 4;
   localparam int DC = 1;
   localparam int BF = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   display_scan_ctrl_if bus();

   display_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int t = 0;   // edges since the last reset edge (0 = the reset edge itself)

   logic [1:0] e_sel;
   logic [3:0] e_an;
   logic       e_dp, e_tick, e_ph;

   typedef struct {
      logic       on;
      logic [3:0] be;
      logic [3:0] dm;
      logic [1:0] sel;
      logic [3:0] an;
      logic       dp;
      logic       tick;
   } vec_t;
   vec_t tbl[17];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
      end
   endtask

   // Timeline model: everything follows from t and the inputs seen at the edge.
   task automatic model(input logic was_rst);
      int slot, off;
      logic dead, blank;
      if (was_rst) begin
         e_sel = 2'd0; e_an = 4'b1111; e_dp = 1'b1; e_tick = 1'b0; e_ph = 1'b0;
      end else begin
         slot   = t / RD;
         off    = t % RD;
         e_sel  = 2'(slot % 4);
         dead   = (slot > 0) && (off < DC);
         e_tick = (slot > 0) && (off == 0);
         e_ph   = ((t / (RD * 4 * BF)) % 2) == 1;
         blank  = !bus.display_on || dead || (e_ph && bus.blink_en[e_sel]);
         e_an   = blank ? 4'b1111 : ~(4'b0001 << e_sel);
         e_dp   = blank ? 1'b1 : ~bus.dp_mask[e_sel];
      end
   endtask

   task automatic step();
      logic was_rst;
      @(posedge clk);
      was_rst = !rst_n;
      if (was_rst) t = 0; else t++;
      model(was_rst);
      @(negedge clk);
      check("sel",         {6'd0, bus.sel},         {6'd0, e_sel});
      check("anode_n",     {4'd0, bus.anode_n},     {4'd0, e_an});
      check("dp_n",        {7'd0, bus.dp_n},        {7'd0, e_dp});
      check("digit_tick",  {7'd0, bus.digit_tick},  {7'd0, e_tick});
      check("blink_phase", {7'd0, bus.blink_phase}, {7'd0, e_ph});
      check("onehot", {7'd0, ($countones(~bus.anode_n) <= 1)}, 8'd1);
   endtask

   initial begin
      // Directed vectors for t = 1..17 after reset release.
      tbl[0]  = '{1'b1, 4'h0, 4'b0010, 2'd0, 4'b1110, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 4'h0, 4'b0010, 2'd0, 4'b1110, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 4'h0, 4'b0010, 2'd0, 4'b1110, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 4'h0, 4'b0010, 2'd1, 4'b1111, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 4'h0, 4'b0010, 2'd1, 4'b1101, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 4'h0, 4'b0010, 2'd1, 4'b1101, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 4'h0, 4'b0010, 2'd1, 4'b1101, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 4'h0, 4'b0010, 2'd2, 4'b1111, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 4'h0, 4'b0010, 2'd2, 4'b1011, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 4'h0, 4'b0010, 2'd2, 4'b1111, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 4'h0, 4'b0010, 2'd2, 4'b1011, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 4'h0, 4'b0010, 2'd3, 4'b1111, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 4'h0, 4'b0010, 2'd3, 4'b0111, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 4'h0, 4'b1000, 2'd3, 4'b0111, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 4'h0, 4'b0010, 2'd3, 4'b0111, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 4'h0, 4'b0010, 2'd0, 4'b1111, 1'b1, 1'b1};
      tbl[16] = '{1'b1, 4'h0, 4'b0010, 2'd0, 4'b1110, 1'b1, 1'b0};

      bus.display_on = 1'b1;
      bus.blink_en   = 4'h0;
      bus.dp_mask    = 4'b0010;

      // Reset edges: outputs at reset values.
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         bus.display_on = tbl[i].on;
         bus.blink_en   = tbl[i].be;
         bus.dp_mask    = tbl[i].dm;
         step();
         check("tbl_sel",  {6'd0, bus.sel},        {6'd0, tbl[i].sel});
         check("tbl_an",   {4'd0, bus.anode_n},    {4'd0, tbl[i].an});
         check("tbl_dp",   {7'd0, bus.dp_n},       {7'd0, tbl[i].dp});
         check("tbl_tick", {7'd0, bus.digit_tick}, {7'd0, tbl[i].tick});
      end

      // Blink on digit 2 from a fresh reset; display drop mid-slot; mid-run reset.
      rst_n = 1'b0;
      bus.display_on = 1'b1;
      bus.blink_en   = 4'b0100;
      bus.dp_mask    = 4'b0000;
      step();
      rst_n = 1'b1;
      while (t < 106) begin
         bus.display_on = !(t >= 65 && t < 75);
         step();
         if (t == 31) check("phase_before", {7'd0, bus.blink_phase}, 8'd0);
         if (t == 32) begin
            check("phase_toggle", {7'd0, bus.blink_phase}, 8'd1);
            check("toggle_sel0",  {6'd0, bus.sel},         8'd0);
            check("toggle_tick",  {7'd0, bus.digit_tick},  8'd1);
         end
         if (t == 41) check("blink_dark", {4'd0, bus.anode_n}, 8'h0F);
         if (t == 45) check("other_lit",  {4'd0, bus.anode_n}, 8'h07);
         if (t == 70) check("off_anode",  {4'd0, bus.anode_n}, 8'h0F);
      end
      check("pre_rst_sel",   {6'd0, bus.sel},         8'd2);
      check("pre_rst_phase", {7'd0, bus.blink_phase}, 8'd1);
      rst_n = 1'b0;
      step();
      check("rst_sel",   {6'd0, bus.sel},         8'd0);
      check("rst_anode", {4'd0, bus.anode_n},     8'h0F);
      check("rst_phase", {7'd0, bus.blink_phase}, 8'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 3) check("restart_tick", {7'd0, bus.digit_tick}, 8'd1);
      end

      // Random controls with occasional resets.
      for (int k = 0; k < 600; k++) begin
         bus.display_on = ($urandom_range(0, 7) != 0);
         bus.blink_en   = 4'($urandom);
         bus.dp_mask    = 4'($urandom);
         rst_n          = ($urandom_range(0, 149) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
